// File: rtl/async_queue_pkg.sv
// Shared definitions for the clock-domain-crossing queue: Gray encoding, full-mask
// derivation and the payload layout agreed with the dequeue-side sink.
package async_queue_pkg;

  localparam int ASYNC_QUEUE_WIDTH = 43;

  // Payload field positions (msb/lsb), common to source and sink.
  localparam int PL_OPCODE_MSB  = 42;
  localparam int PL_OPCODE_LSB  = 40;
  localparam int PL_PARAM_MSB   = 39;
  localparam int PL_PARAM_LSB   = 38;
  localparam int PL_SIZE_MSB    = 37;
  localparam int PL_SIZE_LSB    = 36;
  localparam int PL_SOURCE_BIT  = 35;
  localparam int PL_CORRUPT_BIT = 34;
  localparam int PL_DENIED_BIT  = 33;
  localparam int PL_DATA_MSB    = 32;
  localparam int PL_DATA_LSB    = 1;
  localparam int PL_LAST_BIT    = 0;

  function automatic logic [31:0] gray_enc(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Gray pattern that distinguishes "full" from "empty" for a 2*depth pointer space.
  function automatic int full_mask(input int depth);
    return depth | (depth >> 1);
  endfunction

endpackage

// File: rtl/async_queue_source_sync_reg_vec.sv
// Multi-flop synchronizer for a vector arriving from the sink clock domain.
module sync_reg_vec #(
  parameter int W      = 1,
  parameter int STAGES = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_queue_source.sv
// Enqueue side of the clock-domain-crossing queue: writes payloads into a register
// memory read by the sink and publishes a Gray-coded write pointer.
module async_queue_source
  import async_queue_pkg::*;
#(
  parameter int WIDTH     = ASYNC_QUEUE_WIDTH,
  parameter int LOG_DEPTH = 0,
  parameter int SYNC      = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enq_valid,
  output logic                            enq_ready,
  input  logic [WIDTH-1:0]                enq_bits,
  output logic [(1<<LOG_DEPTH)*WIDTH-1:0] mem,
  output logic [LOG_DEPTH:0]              widx,
  input  logic [LOG_DEPTH:0]              ridx,
  input  logic                            sink_alive,
  output logic                            source_alive
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int PW    = LOG_DEPTH + 1;
  localparam logic [PW-1:0] FULL_MASK = PW'(full_mask(DEPTH));
  localparam logic [PW-1:0] IDX_MASK  = PW'(DEPTH - 1);

  // Handshake: a transfer happens on a cycle where enq_valid and enq_ready are both 1;
  // enq_ready depends only on registered state, never on enq_valid.

  logic [PW-1:0]          ridx_s;
  logic                   alive_s;
  logic [PW-1:0]          wbin_q, wbin_d, wbin_inc;
  logic [PW-1:0]          widx_q, widx_d;
  logic [DEPTH*WIDTH-1:0] mem_q, mem_d;
  logic                   source_alive_q;
  logic                   full;
  logic                   fire;

  sync_reg_vec #(.W(PW), .STAGES(SYNC)) u_ridx_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (ridx),
    .q_o   (ridx_s)
  );

  sync_reg_vec #(.W(1), .STAGES(SYNC)) u_alive_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (sink_alive),
    .q_o   (alive_s)
  );

  assign full      = (widx_q == (ridx_s ^ FULL_MASK));
  assign enq_ready = alive_s & ~full;
  assign fire      = enq_valid & enq_ready;
  assign wbin_inc  = wbin_q + PW'(1);

  always_comb begin
    wbin_d = wbin_q;
    widx_d = widx_q;
    mem_d  = mem_q;
    if (!alive_s) begin
      // Sink is in reset: rewind so both sides restart from an empty queue.
      wbin_d = '0;
      widx_d = '0;
    end else if (fire) begin
      wbin_d = wbin_inc;
      widx_d = PW'(gray_enc(32'(wbin_inc)));
      for (int i = 0; i < DEPTH; i++) begin
        if ((wbin_q & IDX_MASK) == PW'(i)) mem_d[i*WIDTH +: WIDTH] = enq_bits;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wbin_q         <= '0;
      widx_q         <= '0;
      mem_q          <= '0;
      source_alive_q <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      widx_q         <= widx_d;
      mem_q          <= mem_d;
      source_alive_q <= 1'b1;
    end
  end

  assign widx         = widx_q;
  assign mem          = mem_q;
  assign source_alive = source_alive_q;

endmodule

// File: tb/tb_async_queue_source.sv
// Bench for async_queue_source: a DEPTH=4 instance for fill/drain/wrap/sink-reset
// and a default DEPTH=1 instance.
module tb_async_queue_source;

  localparam int W    = 43;
  localparam int SYNC = 3;

  logic clk = 1'b0;
  logic reset;

  // DEPTH=4 instance
  logic         enq_valid, enq_ready, sink_alive, source_alive;
  logic [W-1:0] enq_bits;
  logic [4*W-1:0] mem;
  logic [2:0]   widx, ridx;

  // DEPTH=1 instance
  logic         enq_valid1, enq_ready1, sink_alive1, source_alive1;
  logic [W-1:0] enq_bits1;
  logic [W-1:0] mem1;
  logic [0:0]   widx1, ridx1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   rbin;

  always #5 clk = ~clk;

  async_queue_source #(.WIDTH(W), .LOG_DEPTH(2), .SYNC(SYNC)) dut (
    .clock(clk), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_bits(enq_bits), .mem(mem), .widx(widx), .ridx(ridx),
    .sink_alive(sink_alive), .source_alive(source_alive)
  );

  async_queue_source dut1 (
    .clock(clk), .reset(reset), .enq_valid(enq_valid1), .enq_ready(enq_ready1),
    .enq_bits(enq_bits1), .mem(mem1), .widx(widx1), .ridx(ridx1),
    .sink_alive(sink_alive1), .source_alive(source_alive1)
  );

  function automatic logic [2:0] g3(input logic [2:0] x);
    return x ^ {1'b0, x[2:1]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts clock edges until the selected enq_ready reaches lvl (bounded).
  task automatic wait_ready(input string tag, input bit sel, input logic lvl, input int exp_cycles);
    int n;
    logic cur;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cur = sel ? enq_ready1 : enq_ready;
    end while (cur !== lvl && n < 50);
    check_val(tag, 64'(n), 64'(exp_cycles));
  endtask

  function automatic logic [W-1:0] slot(input int k);
    return mem[k*W +: W];
  endfunction

  // Sink model: consume the oldest entry and advance the read pointer.
  task automatic sink_pop(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 64'(slot(int'(rbin[1:0]))), 64'(e));
    end
    rbin = rbin + 3'd1;
    ridx = g3(rbin);
  endtask

  initial begin
    logic [2:0] exp_wbin;
    logic [2:0] prev_widx;
    bit         fired;
    int         sent, received, cyc;

    reset = 1'b1;
    enq_valid = 1'b0; enq_bits = '0; ridx = '0; sink_alive = 1'b0;
    enq_valid1 = 1'b0; enq_bits1 = '0; ridx1 = '0; sink_alive1 = 1'b0;
    rbin = '0;
    repeat (3) @(posedge clk);
    step();

    // Reset state
    check_val("rst_ready", 64'(enq_ready), 64'(0));
    check_val("rst_widx", 64'(widx), 64'(0));
    check_val("rst_alive", 64'(source_alive), 64'(0));
    for (int k = 0; k < 4; k++) check_val("rst_mem", 64'(slot(k)), 64'(0));
    check_val("rst_ready1", 64'(enq_ready1), 64'(0));
    check_val("rst_mem1", 64'(mem1), 64'(0));

    reset = 1'b0; sink_alive = 1'b1; sink_alive1 = 1'b1;
    step();
    check_val("src_alive", 64'(source_alive), 64'(1));
    check_val("ready_early", 64'(enq_ready), 64'(0));
    wait_ready("ready_rise", 1'b0, 1'b1, SYNC - 1);

    // Fill four slots
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1;
      enq_bits  = W'(32'hA + k);
      exp_q.push_back(enq_bits);
      step();
      check_val("fill_widx", 64'(widx), 64'(g3(3'(k + 1))));
      check_val("fill_mem", 64'(slot(k)), 64'(32'hA + k));
    end
    check_val("full_ready", 64'(enq_ready), 64'(0));
    enq_bits = W'(32'h77);
    repeat (2) step();
    check_val("full_hold_widx", 64'(widx), 64'(6));
    check_val("full_hold_mem", 64'(slot(0)), 64'(32'hA));
    enq_valid = 1'b0;

    // Drain release: one entry consumed
    sink_pop("drain_data");
    wait_ready("drain_ready", 1'b0, 1'b1, SYNC);
    enq_valid = 1'b1; enq_bits = W'(32'hE);
    exp_q.push_back(enq_bits);
    step();
    enq_valid = 1'b0;
    check_val("drain_widx", 64'(widx), 64'(7));
    check_val("drain_mem", 64'(slot(0)), 64'(32'hE));
    check_val("refull_ready", 64'(enq_ready), 64'(0));

    // Leave two entries queued, then the sink goes into reset
    sink_pop("pop_b");
    sink_pop("pop_c");
    wait_ready("two_q_ready", 1'b0, 1'b1, SYNC);
    sink_alive = 1'b0;
    wait_ready("sink_rst_ready", 1'b0, 1'b0, SYNC);
    check_val("sink_rst_widx_pre", 64'(widx), 64'(7));
    step();
    check_val("sink_rst_widx", 64'(widx), 64'(0));
    check_val("sink_rst_mem0", 64'(slot(0)), 64'(32'hE));
    check_val("sink_rst_mem1", 64'(slot(1)), 64'(32'hB));
    check_val("sink_rst_mem2", 64'(slot(2)), 64'(32'hC));
    check_val("sink_rst_mem3", 64'(slot(3)), 64'(32'hD));

    // Sink comes back empty
    exp_q.delete();
    rbin = '0; ridx = '0; sink_alive = 1'b1;
    wait_ready("sink_back_ready", 1'b0, 1'b1, SYNC);

    // Wrap: ten entries with random producer and sink pacing
    exp_wbin = '0; prev_widx = '0; fired = 1'b0; sent = 0; received = 0; cyc = 0;
    while ((sent < 10 || exp_q.size() > 0) && cyc < 400) begin
      if (fired) exp_wbin = exp_wbin + 3'd1;
      check_val("wrap_widx", 64'(widx), 64'(g3(exp_wbin)));
      check_val("wrap_onebit", 64'($countones(widx ^ prev_widx) <= 1), 64'(1));
      prev_widx = widx;
      if (widx != g3(rbin) && $urandom_range(0, 3) != 0) begin
        sink_pop("wrap_data");
        received++;
      end
      fired = 1'b0;
      if (sent < 10 && $urandom_range(0, 3) != 0) begin
        enq_valid = 1'b1;
        enq_bits  = W'({$urandom(), $urandom()});
        if (enq_ready) begin
          exp_q.push_back(enq_bits);
          fired = 1'b1;
          sent++;
        end
      end else begin
        enq_valid = 1'b0;
      end
      step();
      cyc++;
    end
    enq_valid = 1'b0;
    check_val("wrap_received", 64'(received), 64'(10));
    check_val("wrap_wbin", 64'(exp_wbin), 64'(2));

    // DEPTH=1 instance
    enq_valid1 = 1'b1; enq_bits1 = W'(32'h1234);
    step();
    enq_valid1 = 1'b0;
    check_val("d1_widx", 64'(widx1), 64'(1));
    check_val("d1_mem", 64'(mem1), 64'(32'h1234));
    check_val("d1_full", 64'(enq_ready1), 64'(0));
    ridx1 = 1'b1;
    wait_ready("d1_ready", 1'b1, 1'b1, SYNC);
    enq_valid1 = 1'b1; enq_bits1 = W'(32'h5678);
    step();
    enq_valid1 = 1'b0;
    check_val("d1_widx2", 64'(widx1), 64'(0));
    check_val("d1_mem2", 64'(mem1), 64'(32'h5678));
    check_val("d1_full2", 64'(enq_ready1), 64'(0));

    // Reset mid-stream discards the in-flight write
    ridx = g3(rbin);
    enq_valid = 1'b1; enq_bits = W'(32'h55);
    reset = 1'b1;
    step();
    enq_valid = 1'b0;
    check_val("mid_rst_widx", 64'(widx), 64'(0));
    check_val("mid_rst_mem", 64'(slot(int'(rbin[1:0]))), 64'(0));
    check_val("mid_rst_alive", 64'(source_alive), 64'(0));
    check_val("mid_rst_ready", 64'(enq_ready), 64'(0));
    check_val("mid_rst_mem1", 64'(mem1), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/async_queue_source.md
# async_queue_source

Enqueue (write) side of the team's clock-domain-crossing queue; pairs with the existing dequeue-side sink. It accepts a valid/ready payload stream in its own clock domain and writes each payload into a DEPTH-entry register memory that the sink reads directly. It publishes a Gray-coded write index and accepts the sink's Gray-coded read index through a multi-flop synchronizer. It also exchanges reset/alive handshakes with the sink, so either side can reset without corrupting the other.

## Interface
Parameters:
- WIDTH, 43, payload bits per entry
- LOG_DEPTH, 0, log2 of entry count; DEPTH = 2**LOG_DEPTH (default DEPTH = 1)
- SYNC, 3, synchronizer stages on every input from the sink domain (≥2)

Ports:
- clock  in  1  source-domain clock
- reset  in  1  synchronous, active-high reset
- enq_valid  in  1  producer has payload
- enq_ready  out  1  queue accepts payload this cycle
- enq_bits  in  WIDTH  payload
- mem  out  DEPTH*WIDTH  entry storage, slot i at bits [i*WIDTH +: WIDTH], read asynchronously by the sink
- widx  out  LOG_DEPTH+1  Gray-coded write pointer (registered)
- ridx  in  LOG_DEPTH+1  Gray-coded read pointer from the sink domain (asynchronous)
- sink_alive  in  1  sink-domain "out of reset" flag (asynchronous)
- source_alive  out  1  registered flag: this side is out of reset

## Operation
- Fire = enq_valid & enq_ready.
- ridx_s = ridx passed through SYNC flops. alive_s = sink_alive passed through SYNC flops.
- Internal state: wbin (LOG_DEPTH+1-bit binary write pointer).
- widx is a register holding gray(wbin), where gray(x) = x ^ (x>>1).
- Full when widx == ridx_s ^ FULL_MASK.
  - FULL_MASK = DEPTH | (DEPTH>>1).
  - DEPTH=1: mask is 1, so full ⇔ widx != ridx_s.
- enq_ready = alive_s & ~full. Combinational from registers only; no combinational path from enq_valid.
- On fire:
  - mem slot wbin[LOG_DEPTH-1:0] ← enq_bits (slot 0 when DEPTH=1).
  - wbin ← wbin+1, mod 2**(LOG_DEPTH+1), wrapping naturally.
  - widx ← gray(wbin+1).
- If alive_s == 0: wbin ← 0 and widx ← 0 next cycle, regardless of enq_valid.
  - enq_ready is 0 in this state, so nothing is written.
  - mem is held.
- source_alive: 0 during reset; 1 from the first cycle after reset deasserts.
- Reset (synchronous) clears:
  - wbin, widx, all synchronizer flops, source_alive → 0
  - mem → 0
  - enq_ready therefore 0
- Reset asserted mid-stream aborts any pending transfer. The entry written in the reset cycle is discarded.

## Timing
- Fire in cycle N: mem slot and widx update at the edge ending N, visible in cycle N+1.
- A full queue takes the next fire no earlier than N+1 (back-to-back fires allowed when not full).
- ridx change at the input: reflected in ridx_s, and hence in enq_ready, after SYNC edges.
- sink_alive rise: enq_ready can rise SYNC cycles later.
- sink_alive fall: enq_ready falls SYNC cycles later; widx is 0 one cycle after that.
- Simultaneous fire and full deassertion: enq_ready is evaluated from the current-cycle ridx_s only.
- widx changes at most one Gray bit per cycle. This is mandatory for safe sink sampling.

## Structure
- Package async_queue_pkg holds:
  - gray encode function
  - FULL_MASK computation
  - default WIDTH constant 43, shared with the sink's payload split: [42:40] opcode, [39:38] param, [37:36] size, [35] source, [34] corrupt, [33] denied, [32:1] data, [0] last
- Sub-module sync_reg_vec (width, SYNC stages; synchronous reset to 0). Instantiated once for ridx and once for sink_alive.

## Test plan
- Reset: hold reset 3 cycles → enq_ready=0, widx=0, source_alive=0, mem=0. Release with sink_alive=1 → source_alive=1 next cycle, enq_ready=1 SYNC cycles after the synchronizer fills.
- Fill (LOG_DEPTH=2): ridx=0, four fires with bits 0xA..0xD → widx = 1,3,2,6; mem slots 0–3 = A–D; enq_ready=0 after the 4th fire.
- Drain release: from full, set ridx=gray(1)=1 → enq_ready=1 exactly SYNC cycles later; next fire writes slot 0 and widx=7.
- Wrap: continuous traffic with the sink model tracking 10 entries → wbin wraps 7→0, widx sequence 0,1,3,2,6,7,5,4,0,1; no data loss or reorder.
- Sink reset mid-stream: drop sink_alive with 2 entries queued → after SYNC cycles enq_ready=0; next cycle widx=0; mem unchanged.
- DEPTH=1 default: fire 0x1234 → widx=1, enq_ready=0 until ridx=1 is synchronized (SYNC cycles), then 1.
